// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit and the data RAM: access-size
// encodings, FSM state encoding and the alignment check.
package mem_access_unit_pkg;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } state_e;

    // Reserved size counts as an error alongside real misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MODE_BYTE: bad = 1'b0;
            MODE_HALF: bad = addr_lo[0];
            MODE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between the CPU datapath (master) and
// the load/store unit (slave).
interface mem_access_unit_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/halfword out of a RAM word and sign- or
// zero-extends it to 32 bits; word loads pass straight through.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign shifted = word >> {addr_lo, 3'b000};
    assign lane_b  = shifted[7:0];
    assign lane_h  = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (size)
            MODE_BYTE: data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            MODE_HALF: data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Non-pipelined load/store initiator: accepts one request, checks alignment,
// drives a single RAM access cycle and returns a registered response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  clr,
    mem_access_unit_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] ram_Addr,
    output logic [31:0]           ram_Data_input,
    output logic [1:0]            ram_Mode,
    output logic                  ram_str,
    output logic                  ram_sel,
    output logic                  ram_ld,
    input  logic [31:0]           ram_Data_output
);

    state_e                state_q, state_d;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [31:0]           ext_data;
    logic                  req_err;
    logic                  accept;

    assign req_err = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign accept  = (state_q == StIdle) && bus.req_valid;

    mem_access_unit_load_extend u_load_extend (
        .word        (ram_Data_output),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (ext_data)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                state_d = StResp;
                err_d   = 1'b0;
                rdata_d = we_q ? 32'h0 : ext_data;
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= MODE_WORD;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // Loads always fetch the whole word; lane selection happens locally.
    always_comb begin
        ram_sel        = 1'b0;
        ram_str        = 1'b0;
        ram_Mode       = MODE_WORD;
        ram_Addr       = '0;
        ram_Data_input = 32'h0;
        if (state_q == StAccess) begin
            ram_sel  = 1'b1;
            ram_Addr = addr_q;
            if (we_q) begin
                ram_Mode       = size_q;
                ram_str        = ~clr;
                ram_Data_input = wdata_q;
            end
        end
    end

    assign ram_ld        = 1'b1;
    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the CPU datapath and the data RAM. It accepts one byte, halfword or word request at a time over a valid/ready handshake, checks alignment, and drives the RAM's Addr/Data_input/Mode/str/sel/ld pins. For loads it extracts and sign- or zero-extends the addressed lane, then returns a registered response over a second valid/ready handshake.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte-address width; must equal the RAM's ADDR_WIDTH

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned access or reserved size
- ram_Addr  out  ADDR_WIDTH  to RAM Addr
- ram_Data_input  out  32  to RAM Data_input
- ram_Mode  out  2  to RAM Mode
- ram_str  out  1  to RAM str
- ram_sel  out  1  to RAM sel
- ram_ld  out  1  to RAM ld; tied to 1
- ram_Data_output  in  32  from RAM Data_output; combinational read

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - req_ready=1.
  - When req_valid=1, capture we/size/unsigned/addr/wdata into registers.
  - Error condition: size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]≠00.
  - On error, go to RESP with rsp_err=1 and rsp_rdata=0. Otherwise go to ACCESS.
- ACCESS (exactly one cycle)
  - ram_sel=1; ram_Addr = captured addr.
  - Store: ram_Mode = size, ram_str=1, ram_Data_input = wdata. RAM writes on the edge that ends ACCESS.
  - Load: ram_Mode=10 (word, always), ram_str=0. The word is sampled at the end of ACCESS.
  - Lane extraction is done in this unit, never by the RAM.
    - byte: lane addr[1:0] (00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24])
    - half: addr[1] selects [31:16] or [15:0]
  - Extension: sign-extend from bit 7 or bit 15 unless unsigned; word loads pass through unchanged.
  - Go to RESP.
- RESP
  - rsp_valid=1; rsp_rdata and rsp_err held stable.
  - When rsp_ready=1, go to IDLE. Holds indefinitely otherwise.
- Outside ACCESS: ram_sel=0, ram_str=0, ram_Mode=10, ram_Addr=0, ram_Data_input=0.
- ram_str = (state==ACCESS) & we & ~clr, so a store is suppressed if clr arrives during ACCESS.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all ram_* outputs 0 except ram_Mode=10 and ram_ld=1.

## Timing
- Request accepted at edge k → ACCESS during cycle k+1 → rsp_valid=1 from cycle k+2 (load/store latency 2).
- Error request: rsp_valid=1 from cycle k+1; the RAM is never selected.
- Non-pipelined: req_ready=0 in ACCESS and RESP. The earliest next acceptance is the cycle after the response handshake.
- rsp_rdata is registered and has no combinational path from ram_Data_output to outputs.
- clr in any state: next cycle is IDLE with reset values. An in-flight response is dropped; an in-flight store is not written.
- req_valid is ignored while req_ready=0. No request is lost: the requester holds it until it is accepted.

## Structure
- Shared package (with the RAM): Mode encodings MODE_BYTE=2'b00, MODE_HALF=2'b01, MODE_WORD=2'b10, MODE_RSVD=2'b11; FSM state encoding.
- One natural sub-module, load_extend: combinational lane select plus sign/zero extension from (word, addr[1:0], size, unsigned).

## Test plan
- sw 0xDEADBEEF @0x010, then lw @0x010 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid two cycles after each acceptance.
- sb 0x80 @0x013, then lb @0x013 → 0xFFFFFF80; lbu @0x013 → 0x00000080; lb @0x012 → 0xFFFFFFAD (the other bytes are preserved).
- sh 0x8001 @0x022, then lh @0x022 → 0xFFFF8001; lhu @0x022 → 0x00008001; lw @0x020 → 0x80010000.
- lh @0x011, lw @0x012, request with size 11 → each gives rsp_err=1, rsp_rdata=0, rsp_valid at k+1, ram_sel never asserted.
- Hold rsp_ready=0 for 5 cycles after a load → rsp_valid and rsp_rdata stable, req_ready=0 throughout; the next request is accepted only after the handshake.
- clr during ACCESS of sw 0x12345678 @0x030 → no response, ram_str=0 on that edge, a later lw @0x030 returns the old value.
